multi_switch_pulse_gen: RTL and testbench

Multi-channel successor to the single-switch pulse generator. Each channel synchronises a raw switch or button input, debounces it, detects a selected edge and emits one fixed-length pulse per accepted event. An optional auto-repeat mode produces periodic pulses while the input is held. Sits between board switches/buttons and the SPI accelerometer control logic, for example for a sample trigger or a range-select step.

---
 rtl/multi_switch_pulse_pkg.sv | 46 ++++
 rtl/multi_switch_pulse_gen_channel.sv | 163 ++++++++++++++++
 rtl/multi_switch_pulse_gen.sv | 43 ++++
 tb/tb_multi_switch_pulse_gen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_switch_pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_switch_pulse_pkg
// Description : Shared trigger-mode encodings, per-channel state type and
//               elaboration-time width helpers for multi_switch_pulse_gen.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_switch_pulse_pkg;

    // Trigger mode encodings, shared by every channel
    localparam logic [1:0] MODE_RISE   = 2'b00;
    localparam logic [1:0] MODE_FALL   = 2'b01;
    localparam logic [1:0] MODE_BOTH   = 2'b10;
    localparam logic [1:0] MODE_REPEAT = 2'b11;

    // Per-channel controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        LOCK  = 2'd2
    } ch_state_t;

    // Ceiling log2, used to size counters at elaboration time
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Largest of three timing parameters
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_switch_pulse_gen_channel.sv
`default_nettype none
// ============================================================================
// Module      : switch_pulse_channel
// Description : One switch channel: 2-flop synchroniser, debouncer, edge
//               strobe and pulse/lock/repeat controller.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_pulse_channel
    import multi_switch_pulse_pkg::*;
#(
    parameter int PULSE_LEN       = 25,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       switch_in,
    input  logic [1:0] mode,
    output logic       pulse_out,
    output logic       busy,
    output logic       db_level
);

    localparam int CNT_W = clog2(max3(PULSE_LEN, DEBOUNCE_CYCLES, REPEAT_PERIOD) + 1);

    // Counter terminal values; the debounce count toggles on the edge that
    // would bring it to DEBOUNCE_CYCLES, so its terminal value is one less
    localparam logic [CNT_W-1:0] c_db_last   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_pulse_len = CNT_W'(PULSE_LEN);
    localparam logic [CNT_W-1:0] c_period    = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_event;
    logic             w_toggle;
    logic             w_match;

    ch_state_t        r_state;
    ch_state_t        w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       r_mode;
    logic [1:0]       w_mode_next;
    logic             r_pulse;
    logic             r_busy;

    // Two-flop synchroniser for the raw asynchronous switch level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= switch_in;
            r_sync2 <= r_sync1;
        end
    end

    // The debounced level flips on this edge; the new level is r_sync2
    assign w_toggle = (r_sync2 != r_db) && (r_db_cnt == c_db_last);

    // Does the pending level change qualify as an event under the live mode
    always_comb begin
        w_match = 1'b0;
        case (mode)
            MODE_RISE, MODE_REPEAT: w_match = r_sync2;
            MODE_FALL:              w_match = ~r_sync2;
            MODE_BOTH:              w_match = 1'b1;
            default:                w_match = 1'b0;
        endcase
    end

    // Debounce counter, debounced level and one-cycle event strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db     <= 1'b0;
            r_db_cnt <= '0;
            r_event  <= 1'b0;
        end else begin
            r_event <= w_toggle && w_match;
            if (r_sync2 == r_db) begin
                r_db_cnt <= '0;
            end else if (w_toggle) begin
                r_db     <= ~r_db;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_one;
            end
        end
    end

    // Next-state logic; r_cnt counts cycles since the current pulse started
    // and keeps running through LOCK so repeat pulses stay period-aligned
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_mode_next  = r_mode;
        case (r_state)
            IDLE: begin
                if (r_event) begin
                    w_next_state = PULSE;
                    w_cnt_next   = c_one;
                    w_mode_next  = mode;
                end
            end
            PULSE: begin
                w_cnt_next = r_cnt + c_one;
                if (r_cnt == c_pulse_len) begin
                    w_next_state = LOCK;
                end
            end
            LOCK: begin
                case (r_mode)
                    MODE_RISE: if (!r_db) w_next_state = IDLE;
                    MODE_FALL: if (r_db)  w_next_state = IDLE;
                    MODE_BOTH: w_next_state = IDLE;
                    default: begin
                        if (!r_db) begin
                            w_next_state = IDLE;
                        end else if (r_cnt == c_period) begin
                            w_next_state = PULSE;
                            w_cnt_next   = c_one;
                        end else begin
                            w_cnt_next = r_cnt + c_one;
                        end
                    end
                endcase
                if (w_next_state == IDLE) begin
                    w_cnt_next = '0;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // State, counter, held mode and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mode  <= MODE_RISE;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_mode  <= w_mode_next;
            r_pulse <= (w_next_state == PULSE);
            r_busy  <= (w_next_state != IDLE);
        end
    end

    assign pulse_out = r_pulse;
    assign busy      = r_busy;
    assign db_level  = r_db;

endmodule
`default_nettype wire

// File: rtl/multi_switch_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : multi_switch_pulse_gen
// Description : NUM_CH independent debounced switch-to-pulse channels sharing
//               one trigger-mode selector.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_switch_pulse_gen
    import multi_switch_pulse_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int PULSE_LEN       = 25,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] switch_in,
    input  logic [1:0]        mode,
    output logic [NUM_CH-1:0] pulse_out,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] db_level
);

    // One fully independent channel per switch; mode fans out to all
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        switch_pulse_channel #(
            .PULSE_LEN       (PULSE_LEN),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_channel (
            .clk       (clk),
            .rst_n     (rst_n),
            .switch_in (switch_in[i]),
            .mode      (mode),
            .pulse_out (pulse_out[i]),
            .busy      (busy[i]),
            .db_level  (db_level[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_switch_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_switch_pulse_gen
// Description : Directed self-checking bench with a timestamp-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_switch_pulse_gen;

    localparam int N  = 4;
    localparam int L  = 25;
    localparam int D  = 16;
    localparam int P  = 100;
    localparam int SZ = 8192;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] switch_in = '0;
    logic [1:0]   mode = 2'b00;
    logic [N-1:0] pulse_out;
    logic [N-1:0] busy;
    logic [N-1:0] db_level;

    always #5 clk = ~clk;

    multi_switch_pulse_gen #(
        .NUM_CH          (N),
        .PULSE_LEN       (L),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_PERIOD   (P)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .switch_in (switch_in),
        .mode      (mode),
        .pulse_out (pulse_out),
        .busy      (busy),
        .db_level  (db_level)
    );

    int nchecks = 0;
    int nerrors = 0;

    task automatic check(input string name, input int actual, input int expected);
        nchecks++;
        if (actual != expected) begin
            nerrors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // ---------------- behavioural model ----------------
    // samp[t]: level captured by the first synchroniser flop at posedge t.
    // The debounced level flips at posedge t when the D samples t-D-1..t-2
    // all disagree with it and none predate the previous flip.
    int           cyc = 0;
    logic [N-1:0] samp [0:SZ-1];
    logic [N-1:0] mdb;
    int           last_tog [N];
    bit           act [N];
    int           st [N];
    logic [1:0]   hm [N];
    bit           evp [N];
    logic [N-1:0] exp_pulse;
    logic [N-1:0] exp_busy;

    initial begin
        mdb = '0; exp_pulse = '0; exp_busy = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                samp[cyc % SZ] = '0;
                mdb = '0; exp_pulse = '0; exp_busy = '0;
                for (int ch = 0; ch < N; ch++) begin
                    last_tog[ch] = cyc; act[ch] = 0; evp[ch] = 0; st[ch] = 0; hm[ch] = 2'b00;
                end
            end else begin
                samp[cyc % SZ] = switch_in;
                for (int ch = 0; ch < N; ch++) begin
                    logic old;
                    bit   tog;
                    bit   m;
                    int   age;
                    old = mdb[ch];
                    // pulse / hold behaviour in terms of time since pulse start
                    if (!act[ch]) begin
                        if (evp[ch]) begin
                            act[ch] = 1; st[ch] = cyc; hm[ch] = mode;
                        end
                    end else begin
                        age = cyc - st[ch];
                        if (age > L) begin
                            case (hm[ch])
                                2'b00: if (old == 1'b0) act[ch] = 0;
                                2'b01: if (old == 1'b1) act[ch] = 0;
                                2'b10: act[ch] = 0;
                                default: begin
                                    if (!old) act[ch] = 0;
                                    else if (age == P) st[ch] = cyc;
                                end
                            endcase
                        end
                    end
                    // debounced level
                    tog = (cyc - last_tog[ch] >= D);
                    if (tog) begin
                        for (int j = cyc - D - 1; j <= cyc - 2; j++)
                            if (samp[j % SZ][ch] == old) tog = 0;
                    end
                    m = (mode == 2'b10) || ((mode == 2'b01) ? old : !old);
                    evp[ch] = tog && m;
                    if (tog) begin
                        mdb[ch] = ~old; last_tog[ch] = cyc;
                    end
                    exp_busy[ch]  = act[ch];
                    exp_pulse[ch] = act[ch] && ((cyc - st[ch]) < L);
                end
            end
        end
    end

    // ---------------- compare + event monitor ----------------
    int           nrise [N];
    int           rise_t [N][16];
    int           width [N][16];
    int           busy_fall [N];
    int           db_rises [N];
    logic [N-1:0] prev_p = '0;
    logic [N-1:0] prev_b = '0;
    logic [N-1:0] prev_db = '0;

    task automatic clear_mon();
        for (int ch = 0; ch < N; ch++) begin
            nrise[ch] = 0; busy_fall[ch] = -1; db_rises[ch] = 0;
        end
    endtask

    initial begin
        clear_mon();
        forever begin
            @(posedge clk);
            #1;
            nchecks++;
            if (pulse_out !== exp_pulse) begin
                nerrors++;
                $display("FAIL pulse_out cyc %0d: got %b, expected %b", cyc, pulse_out, exp_pulse);
            end
            nchecks++;
            if (busy !== exp_busy) begin
                nerrors++;
                $display("FAIL busy cyc %0d: got %b, expected %b", cyc, busy, exp_busy);
            end
            nchecks++;
            if (db_level !== mdb) begin
                nerrors++;
                $display("FAIL db_level cyc %0d: got %b, expected %b", cyc, db_level, mdb);
            end
            for (int ch = 0; ch < N; ch++) begin
                if (pulse_out[ch] && !prev_p[ch]) begin
                    if (nrise[ch] < 16) rise_t[ch][nrise[ch]] = cyc;
                    nrise[ch]++;
                end
                if (!pulse_out[ch] && prev_p[ch] && nrise[ch] >= 1 && nrise[ch] <= 16)
                    width[ch][nrise[ch]-1] = cyc - rise_t[ch][nrise[ch]-1];
                if (!busy[ch] && prev_b[ch]) busy_fall[ch] = cyc;
                if (db_level[ch] && !prev_db[ch]) db_rises[ch]++;
            end
            prev_p = pulse_out; prev_b = busy; prev_db = db_level;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick(3);
        clear_mon();
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        int r;
        tick(3);
        check("reset_pulse", int'(pulse_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_db", int'(db_level), 0);
        rst_n = 1'b1;
        clear_mon();

        // 1: rise mode, long hold
        mode = 2'b00;
        switch_in[0] = 1'b1; k = cyc + 1;
        tick(200);
        switch_in[0] = 1'b0; r = cyc + 1;
        tick(40);
        check("t1_count", nrise[0], 1);
        check("t1_latency", rise_t[0][0] - k, 18);
        check("t1_width", width[0][0], 25);
        check("t1_busy_release", busy_fall[0] - r, 18);

        // 2: glitches shorter than the debounce window
        apply_reset();
        mode = 2'b00;
        switch_in[1] = 1'b1; tick(10);
        switch_in[1] = 1'b0; tick(20);
        switch_in[1] = 1'b1; tick(15);
        switch_in[1] = 1'b0; tick(40);
        check("t2_no_pulse", nrise[1], 0);
        check("t2_no_db", db_rises[1], 0);

        // 3: both edges, then short press whose release lands mid-pulse
        apply_reset();
        mode = 2'b10;
        switch_in[2] = 1'b1; k = cyc + 1;
        tick(100);
        switch_in[2] = 1'b0;
        tick(60);
        check("t3_count", nrise[2], 2);
        check("t3_spacing", rise_t[2][1] - rise_t[2][0], 100);
        check("t3_width0", width[2][0], 25);
        check("t3_width1", width[2][1], 25);
        switch_in[2] = 1'b1; tick(20);
        switch_in[2] = 1'b0; tick(60);
        check("t3_short_count", nrise[2], 3);
        check("t3_short_width", width[2][2], 25);

        // 4: auto-repeat
        apply_reset();
        mode = 2'b11;
        switch_in[3] = 1'b1; k = cyc + 1;
        tick(450);
        switch_in[3] = 1'b0; r = cyc + 1;
        tick(60);
        check("t4_count", nrise[3], 5);
        check("t4_first", rise_t[3][0] - k, 18);
        for (int j = 1; j < 5; j++)
            check("t4_period", rise_t[3][j] - rise_t[3][j-1], 100);
        check("t4_busy_release", busy_fall[3] - r, 18);

        // 5: all channels, fall mode, mode changed mid-pulse
        apply_reset();
        mode = 2'b01;
        switch_in = '1;
        tick(40);
        check("t5_no_press_pulse", nrise[0] + nrise[1] + nrise[2] + nrise[3], 0);
        switch_in = '0; r = cyc + 1;
        tick(28);
        mode = 2'b00;
        tick(40);
        for (int ch = 0; ch < N; ch++) begin
            check("t5_count", nrise[ch], 1);
            check("t5_latency", rise_t[ch][0] - r, 18);
            check("t5_width", width[ch][0], 25);
        end

        // 6: reset in the middle of a pulse with the switch still held
        apply_reset();
        mode = 2'b00;
        switch_in[0] = 1'b1;
        tick(28);
        check("t6_pulse_before_reset", int'(pulse_out[0]), 1);
        rst_n = 1'b0;
        #1;
        check("t6_async_pulse", int'(pulse_out), 0);
        check("t6_async_busy", int'(busy), 0);
        check("t6_async_db", int'(db_level), 0);
        clear_mon();
        tick(3);
        rst_n = 1'b1; k = cyc + 1;
        tick(50);
        check("t6_count", nrise[0], 1);
        check("t6_latency", rise_t[0][0] - k, 18);
        check("t6_width", width[0][0], 25);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
`default_nettype wire
